// File: rtl/adi2axis_pkg.sv
// Shared encodings and widths for the ADC-to-AXIS sample packer.
package adi2axis_pkg;

  localparam int SAMPLE_W = 32;
  localparam int WORD_W   = 64;
  localparam int CNT_W    = 28;

  // stat bit positions
  localparam int STAT_OVF    = 31;
  localparam int STAT_DROP   = 30;
  localparam int STAT_ST_HI  = 29;
  localparam int STAT_ST_LO  = 28;
  localparam int STAT_CNT_HI = 27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ALIGN = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

  function automatic logic [SAMPLE_W-1:0] swap_iq(input logic [SAMPLE_W-1:0] s);
    return {s[SAMPLE_W/2-1:0], s[SAMPLE_W-1:SAMPLE_W/2]};
  endfunction

endpackage

// File: rtl/adi2axis_pack.sv
// Packs pairs of 32-bit I/Q samples into 64-bit words, with alignment FSM,
// sticky status and a saturating word counter.
module adi2axis_pack
  import adi2axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_NUM_BYTES = 8,
  parameter bit C_SWAP_IQ                = 1'b0
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESET,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  input  logic                adc_enable,
  input  logic                ovf,
  input  logic                stat_clr,
  output logic [WORD_W-1:0]   ddata,
  output logic                dvalid,
  output logic                dsync,
  output logic [31:0]         stat
);

  generate
    if (C_M_AXIS_TDATA_NUM_BYTES != WORD_W / 8) begin : g_bad_width
      $error("adi2axis_pack: only 8-byte output words are supported");
    end
  endgenerate

  state_e              state;
  logic                phase;
  logic [SAMPLE_W-1:0] low_half;
  logic [CNT_W-1:0]    word_cnt;
  logic                ovf_sticky;
  logic                drop_sticky;
  logic [SAMPLE_W-1:0] sample;
  logic                cnt_max;

  assign sample  = C_SWAP_IQ ? swap_iq(adc_data) : adc_data;
  assign cnt_max = &word_cnt;

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state       <= ST_IDLE;
      phase       <= 1'b0;
      low_half    <= '0;
      ddata       <= '0;
      dvalid      <= 1'b0;
      dsync       <= 1'b0;
      word_cnt    <= '0;
      ovf_sticky  <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          phase <= 1'b0;
          if (adc_enable) state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          if (!adc_enable) begin
            state <= ST_IDLE;
          end else if (adc_valid) begin
            low_half <= sample;
            phase    <= 1'b1;
            state    <= ST_RUN;
            dsync    <= 1'b1;
          end
        end
        ST_RUN: begin
          // disable discards any held half word; the valid in this cycle is dropped
          if (!adc_enable) begin
            state <= ST_IDLE;
            dsync <= 1'b0;
            phase <= 1'b0;
          end else if (adc_valid) begin
            if (!phase) begin
              low_half <= sample;
              phase    <= 1'b1;
            end else begin
              ddata  <= {sample, low_half};
              dvalid <= 1'b1;
              phase  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          dsync <= 1'b0;
          phase <= 1'b0;
        end
      endcase

      // clear first so that a same-cycle set or count overrides it
      if (stat_clr) begin
        ovf_sticky  <= 1'b0;
        drop_sticky <= 1'b0;
        word_cnt    <= '0;
      end
      if (state == ST_RUN && ovf) ovf_sticky <= 1'b1;
      if (state == ST_RUN && !adc_enable && phase) drop_sticky <= 1'b1;
      if (dvalid) begin
        if (stat_clr)      word_cnt <= CNT_W'(1);
        else if (!cnt_max) word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  assign stat[STAT_OVF]               = ovf_sticky;
  assign stat[STAT_DROP]              = drop_sticky;
  assign stat[STAT_ST_HI:STAT_ST_LO]  = state;
  assign stat[STAT_CNT_HI:0]          = word_cnt;

endmodule

// File: tb/tb_adi2axis_pack.sv
// Directed + random bench for adi2axis_pack against a queue-based pairing model.
module tb_adi2axis_pack;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, v, o, c;
  logic [31:0] d;
  logic [63:0] dd, dd_s;
  logic        dv, dv_s, ds, ds_s;
  logic [31:0] st, st_s;

  adi2axis_pack dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst), .adc_data(d), .adc_valid(v),
    .adc_enable(en), .ovf(o), .stat_clr(c),
    .ddata(dd), .dvalid(dv), .dsync(ds), .stat(st)
  );

  adi2axis_pack #(.C_SWAP_IQ(1'b1)) dut_sw (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst), .adc_data(d), .adc_valid(v),
    .adc_enable(en), .ovf(o), .stat_clr(c),
    .ddata(dd_s), .dvalid(dv_s), .dsync(ds_s), .stat(st_s)
  );

  localparam logic [27:0] MAXC = 28'hFFFFFFF;

  int total = 0;
  int bad   = 0;
  int ndv   = 0;
  logic [63:0] got[$];

  // reference model: mode 0=idle 1=align 2=run, queue holds the pending half
  logic [1:0]  ms;
  logic [31:0] pend[$];
  logic [63:0] mword;
  logic        mdv;
  logic [27:0] mcnt;
  logic        movf, mdrop;

  function automatic logic [63:0] swp64(input logic [63:0] w);
    return {w[47:32], w[63:48], w[15:0], w[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic i_r, input logic i_en, input logic i_v,
                     input logic [31:0] i_d, input logic i_o, input logic i_c);
    logic [27:0] c0;
    rst = i_r; en = i_en; v = i_v; d = i_d; o = i_o; c = i_c;
    @(posedge clk);
    if (i_r) begin
      ms = 2'd0; pend.delete(); mword = '0; mdv = 1'b0;
      mcnt = '0; movf = 1'b0; mdrop = 1'b0;
    end else begin
      c0 = i_c ? 28'd0 : mcnt;
      if (mdv && c0 != MAXC) c0 = c0 + 28'd1;
      mcnt = c0;
      if (i_c) begin movf = 1'b0; mdrop = 1'b0; end
      if (ms == 2'd2 && i_o) movf = 1'b1;
      if (ms == 2'd2 && !i_en && pend.size() != 0) mdrop = 1'b1;
      mdv = 1'b0;
      if (ms == 2'd0) begin
        if (i_en) ms = 2'd1;
      end else if (!i_en) begin
        ms = 2'd0;
        pend.delete();
      end else if (i_v) begin
        if (pend.size() == 0) begin
          pend.push_back(i_d);
          ms = 2'd2;
        end else begin
          mword = {i_d, pend.pop_front()};
          mdv = 1'b1;
        end
      end
    end
    #1;
    if (dv) begin ndv++; got.push_back(dd); end
    chk("dvalid", {63'd0, dv}, {63'd0, mdv});
    chk("dsync", {63'd0, ds}, {63'd0, ms == 2'd2});
    chk("stat", {32'd0, st}, {32'd0, movf, mdrop, ms, mcnt});
    chk("ddata", dd, mword);
    chk("sw_dvalid", {63'd0, dv_s}, {63'd0, mdv});
    chk("sw_ddata", dd_s, swp64(mword));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; v = 1'b0; d = '0; o = 1'b0; c = 1'b0;
    ms = '0; mword = '0; mdv = 1'b0; mcnt = '0; movf = 1'b0; mdrop = 1'b0;

    // reset held with enable high must stay idle
    cyc(1, 1, 1, 32'h1, 0, 0);
    cyc(1, 1, 0, 32'h0, 0, 0);

    // basic packing
    cyc(0, 1, 1, 32'hDEADBEEF, 0, 0);
    cyc(0, 1, 1, 32'h11110000, 0, 0);
    cyc(0, 1, 1, 32'h22220001, 0, 0);
    cyc(0, 1, 1, 32'h33330002, 0, 0);
    cyc(0, 1, 1, 32'h44440003, 0, 0);
    cyc(0, 1, 0, 32'h0, 0, 0);
    cyc(0, 1, 0, 32'h0, 0, 0);
    chk("basic_n", got.size(), 2);
    chk("basic_w0", got.size() > 0 ? got[0] : 64'hx, 64'h2222000111110000);
    chk("basic_w1", got.size() > 1 ? got[1] : 64'hx, 64'h4444000333330002);
    chk("basic_cnt", st[27:0], 2);

    // sparse valid
    ndv = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 1, $urandom, 0, 0);
      cyc(0, 1, 0, $urandom, 0, 0);
      cyc(0, 1, 0, $urandom, 0, 0);
    end
    chk("sparse_n", ndv, 3);

    // odd drop
    cyc(0, 1, 0, 32'h0, 0, 1);
    ndv = 0;
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, $urandom, 0, 0);
    cyc(0, 0, 1, $urandom, 0, 0);
    chk("drop_state", st[29:28], 2'b00);
    chk("drop_dsync", ds, 0);
    cyc(0, 0, 0, 32'h0, 0, 0);
    chk("drop_n", ndv, 1);
    chk("drop_sticky", st[30], 1);

    // overflow
    cyc(0, 1, 0, 32'h0, 0, 1);
    cyc(0, 1, 1, $urandom, 0, 0);
    cyc(0, 1, 0, 32'h0, 1, 0);
    chk("ovf_set", st[31], 1);
    cyc(0, 1, 0, 32'h0, 0, 1);
    chk("ovf_clr", st[31], 0);
    cyc(0, 0, 0, 32'h0, 0, 1);
    cyc(0, 0, 0, 32'h0, 1, 0);
    chk("ovf_idle", st[31], 0);

    // saturation and clear collision
    force dut.word_cnt = 28'hFFFFFFE;
    #1;
    release dut.word_cnt;
    mcnt = 28'hFFFFFFE;
    cyc(0, 1, 0, 32'h0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, $urandom, 0, 0);
    cyc(0, 1, 0, 32'h0, 0, 0);
    cyc(0, 1, 0, 32'h0, 0, 0);
    chk("sat_cnt", st[27:0], MAXC);
    cyc(0, 1, 1, $urandom, 0, 0);
    cyc(0, 1, 1, $urandom, 0, 0);
    chk("coll_dv", dv, 1);
    cyc(0, 1, 0, 32'h0, 0, 1);
    chk("coll_cnt", st[27:0], 1);

    // reset mid-word, then swap check
    cyc(0, 1, 1, $urandom, 0, 0);
    cyc(1, 1, 1, $urandom, 0, 0);
    chk("rst_ddata", dd, 0);
    chk("rst_stat", st, 0);
    chk("rst_dv", dv, 0);
    cyc(0, 1, 1, $urandom, 0, 0);
    chk("rst_dv_after", dv, 0);
    chk("rst_drop", st[30], 0);
    cyc(0, 1, 1, 32'hAAAA5555, 0, 0);
    cyc(0, 1, 1, 32'h12345678, 0, 0);
    cyc(0, 1, 0, 32'h0, 0, 0);
    chk("swap_lo", dd_s[31:0], 32'h5555AAAA);
    chk("swap_hi", dd_s[63:32], 32'h56781234);

    // random traffic
    for (int k = 0; k < 400; k++)
      cyc(($urandom % 150) == 0, ($urandom % 16) != 0, $urandom % 2, $urandom,
          ($urandom % 8) == 0, ($urandom % 20) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adi2axis_pack.md
ADI2AXIS_PACK -- requirements
Module: adi2axis_pack

Interface
REQ-001 SHALL have parameter C_M_AXIS_TDATA_NUM_BYTES, default 8, output word width in bytes; only 8 is supported, and any other value SHALL fail elaboration.
REQ-002 SHALL have parameter C_SWAP_IQ, default 0; when set to 1, I and Q halves are exchanged within each 32-bit sample before packing.
REQ-003 SHALL have port AXIS_ACLK, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port AXIS_ARESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port adc_data, input, 32 bits: one sample, with I in [15:0] and Q in [31:16].
REQ-006 SHALL have port adc_valid, input, 1 bit: adc_data is valid this cycle.
REQ-007 SHALL have port adc_enable, input, 1 bit: capture enable (level).
REQ-008 SHALL have port ovf, input, 1 bit: overflow flag from the downstream converter.
REQ-009 SHALL have port stat_clr, input, 1 bit: single-cycle pulse that clears the sticky status bits and the word counter.
REQ-010 SHALL have port ddata, output, 64 bits: packed word, with the older sample in [31:0] and the newer sample in [63:32].
REQ-011 SHALL have port dvalid, output, 1 bit: one-cycle strobe marking ddata as valid.
REQ-012 SHALL have port dsync, output, 1 bit: stream-aligned indicator, high only in state RUN.
REQ-013 SHALL have port stat, output, 32 bits: {ovf_sticky, drop_sticky, state[1:0], word_cnt[27:0]}.

Function
REQ-014 SHALL implement states IDLE, ALIGN and RUN, encoded 2'b00, 2'b01 and 2'b10.
REQ-015 SHALL transition IDLE->ALIGN in the cycle after adc_enable is sampled high; adc_valid in that cycle is ignored.
REQ-016 SHALL, in ALIGN, capture the first adc_valid sample into the low half-register, set phase=1, and enter RUN.
REQ-017 SHALL, in RUN with phase=0, capture an adc_valid sample into the low half and set phase=1.
REQ-018 SHALL, in RUN with phase=1, form ddata = {new sample, low half} on an adc_valid sample, assert dvalid for exactly one cycle on the next edge, and set phase=0.
REQ-019 SHALL provide a latency of 1 cycle from the adc_valid of the second sample to dvalid; ddata SHALL hold its value until the next word is formed.
REQ-020 SHALL never assert dvalid on two consecutive cycles, which is guaranteed by pairing.
REQ-021 SHALL hold dsync=1 in RUN and dsync=0 in IDLE/ALIGN, with dsync registered and changing on the same edge as the state.
REQ-022 SHALL, when adc_enable is low in ALIGN or RUN, go to IDLE on the next edge; an adc_valid in that same cycle is discarded.
REQ-023 SHALL, when adc_enable falls with phase=1, discard the half word, set drop_sticky, and not assert dvalid.
REQ-024 SHALL increment word_cnt by 1 per dvalid, saturating at 28'hFFFFFFF with no wrap.
REQ-025 SHALL set ovf_sticky on any cycle with ovf=1 while in RUN, and ignore ovf in IDLE/ALIGN.
REQ-026 SHALL clear ovf_sticky, drop_sticky and word_cnt on stat_clr; a simultaneous set or increment SHALL win over the clear (the counter reads 1 after the edge).
REQ-027 SHALL NOT let stat_clr affect state, phase, ddata or dvalid.
REQ-028 SHALL make stat combinational from registered state only.

Reset
REQ-029 SHALL, on AXIS_ARESET=1 at an edge, reset: state=IDLE, phase=0, ddata=0, dvalid=0, dsync=0, word_cnt=0, ovf_sticky=0 and drop_sticky=0.
REQ-030 SHALL apply reset mid-word by abandoning any held half word without setting drop_sticky, with no dvalid in the reset cycle or the one after it.
REQ-031 SHALL NOT leave IDLE while AXIS_ARESET is high, regardless of adc_enable.

Structure
REQ-032 SHALL place the state encodings, the stat bit positions (31, 30, 29:28, 27:0) and the sample/word widths (32 and 64) in shared package adi2axis_pkg.
REQ-033 SHALL be a single flat module; no sub-module is required.
REQ-034 SHALL hold the saturating counter and the half-register inline.

Verification
REQ-035 SHALL check basic packing: enable, then adc_valid every cycle with samples 0x11110000, 0x22220001, 0x33330002 and 0x44440003 -> dvalid pulses twice, ddata=0x2222000111110000 then 0x4444000333330002, and word_cnt=2.
REQ-036 SHALL check sparse valid: adc_valid every 3rd cycle with 6 samples -> 3 dvalid pulses, each exactly 1 cycle after the 2nd sample of its pair, and dsync steady high.
REQ-037 SHALL check odd drop: 3 samples, then adc_enable=0 -> 1 dvalid, drop_sticky=1, state returns to IDLE (stat[29:28]=00), and dsync falls on the same edge.
REQ-038 SHALL check overflow: ovf=1 for 1 cycle in RUN -> stat[31]=1; stat_clr then -> stat[31]=0; ovf=1 in IDLE -> stat[31] stays 0.
REQ-039 SHALL check saturation and clear collision: preload word_cnt to 28'hFFFFFFE, then 3 words -> word_cnt=28'hFFFFFFF; stat_clr coincident with a dvalid -> word_cnt=1.
REQ-040 SHALL check reset mid-word: AXIS_ARESET after 1 sample in RUN -> all outputs 0 next edge, no dvalid, drop_sticky=0; with C_SWAP_IQ=1 a sample 0xAAAA5555 packs as 0x5555AAAA.
